// File: rtl/vga_pkg.sv
// Shared VGA definitions for the pixel pipeline.
// Holds the default active-area geometry (shared with vga_sync), the test-pattern
// mode encoding, the packed RGB type with named colours, and the per-axis bounce
// step used by the bouncing-box animation.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 800;
  localparam int unsigned VGA_V_ACTIVE = 600;

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    CHECKER  = 2'd1,
    GRADIENT = 2'd2,
    BOX      = 2'd3
  } pattern_mode_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t ColWhite   = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t ColYellow  = '{r: 4'hF, g: 4'hF, b: 4'h0};
  localparam rgb_t ColCyan    = '{r: 4'h0, g: 4'hF, b: 4'hF};
  localparam rgb_t ColGreen   = '{r: 4'h0, g: 4'hF, b: 4'h0};
  localparam rgb_t ColMagenta = '{r: 4'hF, g: 4'h0, b: 4'hF};
  localparam rgb_t ColRed     = '{r: 4'hF, g: 4'h0, b: 4'h0};
  localparam rgb_t ColBlue    = '{r: 4'h0, g: 4'h0, b: 4'hF};
  localparam rgb_t ColBlack   = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t ColBoxBg   = '{r: 4'h0, g: 4'h0, b: 4'h8};

  // Position and velocity of one box axis; both hold 12-bit two's complement values.
  typedef struct packed {
    logic [11:0] pos;
    logic [11:0] vel;
  } axis_t;

  function automatic rgb_t bar_colour(logic [2:0] idx);
    case (idx)
      3'd0:    return ColWhite;
      3'd1:    return ColYellow;
      3'd2:    return ColCyan;
      3'd3:    return ColGreen;
      3'd4:    return ColMagenta;
      3'd5:    return ColRed;
      3'd6:    return ColBlue;
      default: return ColBlack;
    endcase
  endfunction

  // One frame of motion: clamp to [0, max_pos] and reverse direction on overshoot.
  function automatic axis_t axis_step(axis_t cur, logic [11:0] max_pos, logic [11:0] step);
    axis_t             nxt;
    logic signed [11:0] sum;
    nxt = cur;
    sum = $signed(cur.pos) + $signed(cur.vel);
    if (sum > $signed(max_pos)) begin
      nxt.pos = max_pos;
      nxt.vel = 12'd0 - step;
    end else if (sum < 12'sd0) begin
      nxt.pos = 12'd0;
      nxt.vel = step;
    end else begin
      nxt.pos = sum;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video bus between vga_sync-side logic and the pattern generator.
// Inputs to the generator: sync pair, active-video qualifier, pixel coordinates, mode.
// Outputs from the generator: 4-bit RGB, realigned sync pair, frame counter.
// master: the side that sources timing and sinks pixels; slave: the pattern generator.
interface vga_pattern_gen_if;
  logic        h_sync_in;
  logic        v_sync_in;
  logic        display_on_in;
  logic [10:0] pixel_x_in;
  logic [9:0]  pixel_y_in;
  logic [1:0]  mode_in;
  logic [3:0]  red_out;
  logic [3:0]  green_out;
  logic [3:0]  blue_out;
  logic        h_sync_out;
  logic        v_sync_out;
  logic [15:0] frame_count_out;

  modport master (
    output h_sync_in, v_sync_in, display_on_in, pixel_x_in, pixel_y_in, mode_in,
    input  red_out, green_out, blue_out, h_sync_out, v_sync_out, frame_count_out
  );

  modport slave (
    input  h_sync_in, v_sync_in, display_on_in, pixel_x_in, pixel_y_in, mode_in,
    output red_out, green_out, blue_out, h_sync_out, v_sync_out, frame_count_out
  );
endinterface

// File: rtl/vga_box_mover.sv
// Bouncing-box position tracker.
// Ports: clk, rst (async, active-high), frame_end (advance one step);
//        box_x / box_y give the top-left corner of the box for the current frame.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned BOX_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_end,
  output logic [10:0] box_x,
  output logic [9:0]  box_y
);

  localparam logic [11:0] MaxX = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] MaxY = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] Step = 12'(BOX_STEP);

  axis_t x_q, x_d, y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_end) begin
      x_d = axis_step(x_q, MaxX, Step);
      y_d = axis_step(y_q, MaxY, Step);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '{pos: 12'd0, vel: Step};
      y_q <= '{pos: 12'd0, vel: Step};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Positions never leave [0, MAX], so the upper bits are always zero here.
  assign box_x = x_q.pos[10:0];
  assign box_y = y_q.pos[9:0];

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel stage downstream of vga_sync.
// Ports: vga_clk_in (pixel clock), reset_in (async, active-high),
//        vif (slave side of vga_pattern_gen_if: timing/coordinates/mode in,
//        registered RGB, sync delayed by 2 and frame counter out).
// Mode and box motion change only at the last visible pixel of a frame, so each
// frame is drawn entirely with one mode and one box position.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned BOX_SIZE  = 32,
  parameter int unsigned BOX_STEP  = 4,
  parameter logic        SYNC_IDLE = 1'b1
) (
  input  logic             vga_clk_in,
  input  logic             reset_in,
  vga_pattern_gen_if.slave vif
);

  localparam int unsigned BarW = H_ACTIVE / 8;

  logic          frame_end;
  pattern_mode_t mode_q, mode_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [10:0]   box_x;
  logic [9:0]    box_y;

  assign frame_end = vif.display_on_in
                   && (vif.pixel_x_in == 11'(H_ACTIVE - 1))
                   && (vif.pixel_y_in == 10'(V_ACTIVE - 1));

  always_comb begin
    mode_d        = mode_q;
    frame_count_d = frame_count_q;
    if (frame_end) begin
      mode_d        = pattern_mode_t'(vif.mode_in);
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box_mover (
    .clk       (vga_clk_in),
    .rst       (reset_in),
    .frame_end (frame_end),
    .box_x     (box_x),
    .box_y     (box_y)
  );

  // Pattern colour for the current pixel, using the pre-update mode and box.
  logic [2:0]  bar_idx;
  logic [11:0] x_w, y_w, bx_w, by_w;
  logic        in_box;
  rgb_t        pattern;

  always_comb begin
    // Bar index from constant thresholds; no divider in hardware.
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (vif.pixel_x_in >= 11'(i * BarW)) bar_idx = 3'(i);
    end
    x_w    = {1'b0, vif.pixel_x_in};
    y_w    = {2'b00, vif.pixel_y_in};
    bx_w   = {1'b0, box_x};
    by_w   = {2'b00, box_y};
    in_box = (x_w >= bx_w) && (x_w < bx_w + 12'(BOX_SIZE))
          && (y_w >= by_w) && (y_w < by_w + 12'(BOX_SIZE));
    pattern = ColBlack;
    case (mode_q)
      BARS:     pattern = bar_colour(bar_idx);
      CHECKER:  pattern = (vif.pixel_x_in[5] ^ vif.pixel_y_in[5]) ? ColWhite : ColBlack;
      GRADIENT: pattern = '{r: vif.pixel_x_in[7:4], g: vif.pixel_y_in[7:4], b: 4'h0};
      BOX:      pattern = in_box ? ColWhite : ColBoxBg;
      default:  pattern = ColBlack;
    endcase
  end

  // Two-stage pipeline: stage 1 holds raw colour + timing, stage 2 applies blanking.
  rgb_t rgb_s1_q, rgb_s2_q, rgb_s2_d;
  logic hs_s1_q, vs_s1_q, de_s1_q;
  logic hs_s2_q, vs_s2_q;

  always_comb begin
    rgb_s2_d = de_s1_q ? rgb_s1_q : ColBlack;
  end

  always_ff @(posedge vga_clk_in or posedge reset_in) begin
    if (reset_in) begin
      mode_q        <= BARS;
      frame_count_q <= 16'd0;
      rgb_s1_q      <= ColBlack;
      hs_s1_q       <= SYNC_IDLE;
      vs_s1_q       <= SYNC_IDLE;
      de_s1_q       <= 1'b0;
      rgb_s2_q      <= ColBlack;
      hs_s2_q       <= SYNC_IDLE;
      vs_s2_q       <= SYNC_IDLE;
    end else begin
      mode_q        <= mode_d;
      frame_count_q <= frame_count_d;
      rgb_s1_q      <= pattern;
      hs_s1_q       <= vif.h_sync_in;
      vs_s1_q       <= vif.v_sync_in;
      de_s1_q       <= vif.display_on_in;
      rgb_s2_q      <= rgb_s2_d;
      hs_s2_q       <= hs_s1_q;
      vs_s2_q       <= vs_s1_q;
    end
  end

  assign vif.red_out         = rgb_s2_q.r;
  assign vif.green_out       = rgb_s2_q.g;
  assign vif.blue_out        = rgb_s2_q.b;
  assign vif.h_sync_out      = hs_s2_q;
  assign vif.v_sync_out      = vs_s2_q;
  assign vif.frame_count_out = frame_count_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: table of pixel vectors, hand-written
// sequences for mode switching, box bounce, async reset and counter wrap, with a
// scoreboard queue that lines each driven pixel up with the output two cycles later.
module tb_vga_pattern_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  vga_pattern_gen_if vif ();

  vga_pattern_gen #(
    .H_ACTIVE  (800),
    .V_ACTIVE  (600),
    .BOX_SIZE  (32),
    .BOX_STEP  (4),
    .SYNC_IDLE (1'b1)
  ) dut (
    .vga_clk_in (clk),
    .reset_in   (rst),
    .vif        (vif)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    string       name;
  } exp_t;

  typedef struct {
    int          mode;
    int          x;
    int          y;
    bit          de;
    logic [11:0] rgb;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[17];

  // Reference model state.
  int m_mode, m_bx, m_by, m_vx, m_vy, m_fc;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_bx = 0; m_by = 0; m_vx = 4; m_vy = 4; m_fc = 0;
  endfunction

  function automatic void model_frame_end(int mode);
    m_mode = mode;
    m_fc   = (m_fc + 1) % 65536;
    m_bx  += m_vx;
    if (m_bx > 768) begin m_bx = 768; m_vx = -4; end
    else if (m_bx < 0) begin m_bx = 0; m_vx = 4; end
    m_by  += m_vy;
    if (m_by > 568) begin m_by = 568; m_vy = -4; end
    else if (m_by < 0) begin m_by = 0; m_vy = 4; end
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, bit de);
    if (!de) return 12'h000;
    case (m_mode)
      0: begin
        case (x / 100)
          0: return 12'hFFF;
          1: return 12'hFF0;
          2: return 12'h0FF;
          3: return 12'h0F0;
          4: return 12'hF0F;
          5: return 12'hF00;
          6: return 12'h00F;
          default: return 12'h000;
        endcase
      end
      1: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
      2: return {4'((x >> 4) & 15), 4'((y >> 4) & 15), 4'h0};
      default: begin
        if (x >= m_bx && x < m_bx + 32 && y >= m_by && y < m_by + 32) return 12'hFFF;
        return 12'h008;
      end
    endcase
  endfunction

  // One pixel cycle: score the pixel driven two cycles ago, then drive a new one.
  task automatic step(int x, int y, bit de, int mode, bit use_exp, logic [11:0] want,
                      string name);
    exp_t e;
    logic hs, vs;
    @(negedge clk);
    check("frame_count", {16'd0, vif.frame_count_out}, m_fc);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check({e.name, "_rgb"}, {20'd0, vif.red_out, vif.green_out, vif.blue_out}, {20'd0, e.rgb});
      check({e.name, "_sync"}, {30'd0, vif.h_sync_out, vif.v_sync_out}, {30'd0, e.hs, e.vs});
    end
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    vif.h_sync_in     = hs;
    vif.v_sync_in     = vs;
    vif.display_on_in = de;
    vif.pixel_x_in    = 11'(x);
    vif.pixel_y_in    = 10'(y);
    vif.mode_in       = 2'(mode);
    e.rgb  = use_exp ? want : model_rgb(x, y, de);
    e.hs   = hs;
    e.vs   = vs;
    e.name = name;
    sb.push_back(e);
    if (de && x == 799 && y == 599) model_frame_end(mode);
  endtask

  task automatic fe(int mode);
    step(799, 599, 1'b1, mode, 1'b0, 12'h000, "frame_end_px");
  endtask

  task automatic flush();
    step(0, 0, 1'b0, m_mode, 1'b0, 12'h000, "flush");
    step(0, 0, 1'b0, m_mode, 1'b0, 12'h000, "flush");
  endtask

  task automatic check_box(int ex, int ey);
    step(ex, ey, 1'b1, 3, 1'b1, 12'hFFF, "box_top_left");
    step(ex + 31, ey + 31, 1'b1, 3, 1'b1, 12'hFFF, "box_bot_right");
    step(ex - 1, ey, 1'b1, 3, 1'b1, 12'h008, "box_left_out");
    step(ex, ey + 32, 1'b1, 3, 1'b1, 12'h008, "box_below_out");
    step(ex + 32, ey + 31, 1'b1, 3, 1'b1, 12'h008, "box_right_out");
  endtask

  // Assert reset between clock edges and check outputs before any edge arrives.
  task automatic do_reset(string name);
    @(negedge clk);
    #1;
    rst = 1'b1;
    vif.h_sync_in     = 1'b0;
    vif.v_sync_in     = 1'b0;
    vif.display_on_in = 1'b0;
    #1;
    check({name, "_rst_rgb"}, {20'd0, vif.red_out, vif.green_out, vif.blue_out}, 32'd0);
    check({name, "_rst_hsync"}, {31'd0, vif.h_sync_out}, 32'd1);
    check({name, "_rst_vsync"}, {31'd0, vif.v_sync_out}, 32'd1);
    check({name, "_rst_count"}, {16'd0, vif.frame_count_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_reset();
  endtask

  initial begin
    vecs[0]  = '{0, 150, 10, 1'b1, 12'hFF0, "bar_yellow"};
    vecs[1]  = '{0, 750, 10, 1'b1, 12'h000, "bar_black"};
    vecs[2]  = '{0, 0, 10, 1'b1, 12'hFFF, "bar_white"};
    vecs[3]  = '{0, 250, 20, 1'b1, 12'h0FF, "bar_cyan"};
    vecs[4]  = '{0, 350, 20, 1'b1, 12'h0F0, "bar_green"};
    vecs[5]  = '{0, 450, 30, 1'b1, 12'hF0F, "bar_magenta"};
    vecs[6]  = '{0, 550, 30, 1'b1, 12'hF00, "bar_red"};
    vecs[7]  = '{0, 650, 40, 1'b1, 12'h00F, "bar_blue"};
    vecs[8]  = '{0, 99, 5, 1'b1, 12'hFFF, "bar_edge_99"};
    vecs[9]  = '{0, 100, 5, 1'b1, 12'hFF0, "bar_edge_100"};
    vecs[10] = '{1, 32, 0, 1'b1, 12'hFFF, "checker_32_0"};
    vecs[11] = '{1, 32, 32, 1'b1, 12'h000, "checker_32_32"};
    vecs[12] = '{1, 31, 32, 1'b1, 12'hFFF, "checker_31_32"};
    vecs[13] = '{1, 32, 0, 1'b0, 12'h000, "checker_blank"};
    vecs[14] = '{2, 'hA5, 'h3C, 1'b1, 12'hA30, "gradient_a5_3c"};
    vecs[15] = '{2, 'h12, 'hF0, 1'b1, 12'h1F0, "gradient_12_f0"};
    vecs[16] = '{2, 'hA5, 'h3C, 1'b0, 12'h000, "gradient_blank"};

    vif.h_sync_in = 1'b0; vif.v_sync_in = 1'b0; vif.display_on_in = 1'b0;
    vif.pixel_x_in = '0; vif.pixel_y_in = '0; vif.mode_in = '0;
    model_reset();
    do_reset("init");

    // Table vectors; a frame_end pixel selects each new mode.
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].mode != m_mode) fe(vecs[i].mode);
      step(vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].mode, 1'b1, vecs[i].rgb, vecs[i].name);
    end

    // Mid-frame mode change only takes effect after frame_end.
    step('hA5, 'h3C, 1'b1, 0, 1'b1, 12'hA30, "switch_still_gradient");
    step('h20, 'h10, 1'b1, 1, 1'b1, 12'h210, "switch_still_gradient2");
    step(799, 599, 1'b1, 0, 1'b1, 12'h150, "switch_frame_end_old_mode");
    step(150, 10, 1'b1, 2, 1'b1, 12'hFF0, "switch_new_mode_bars");
    flush();

    // Bouncing box from reset.
    do_reset("box");
    for (int i = 0; i < 3; i++) fe(3);
    check_box(12, 12);
    flush();
    check("count_after_3", {16'd0, vif.frame_count_out}, 32'd3);
    while (m_fc < 142) fe(3);
    check_box(568, 568);
    fe(3);
    check_box(572, 568);
    fe(3);
    check_box(576, 564);
    while (m_fc < 191) fe(3);
    check_box(764, 376);
    fe(3);
    check_box(768, 372);
    fe(3);
    check_box(768, 368);
    fe(3);
    check_box(764, 364);

    // Async reset mid-line with a white pixel on the outputs.
    step(764, 364, 1'b1, 3, 1'b1, 12'hFFF, "pre_reset_white");
    step(764, 364, 1'b1, 3, 1'b1, 12'hFFF, "pre_reset_white");
    do_reset("midline");
    step(150, 10, 1'b1, 3, 1'b1, 12'hFF0, "post_reset_bars");
    step(0, 0, 1'b1, 3, 1'b1, 12'hFFF, "post_reset_bars_white");
    flush();
    check("post_reset_count", {16'd0, vif.frame_count_out}, 32'd0);

    // Frame counter wrap.
    for (int i = 0; i < 65535; i++) fe(1);
    flush();
    check("count_ffff", {16'd0, vif.frame_count_out}, 32'hFFFF);
    fe(1);
    flush();
    check("count_wrap", {16'd0, vif.frame_count_out}, 32'd0);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
